// File: rtl/mtl_feeder_pkg.sv
// Shared constants for the MTL frame feeder: panel geometry, word size, FSM codes.
package mtl_feeder_pkg;

    localparam int unsigned MTL_H           = 800;
    localparam int unsigned MTL_V           = 480;
    localparam int unsigned MTL_FRAME_WORDS = MTL_H * MTL_V;
    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam int unsigned PIXEL_W         = 32;
    localparam int unsigned STATE_W         = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_PREFILL = 2'd1;
    localparam logic [STATE_W-1:0] ST_STREAM  = 2'd2;

endpackage

// File: rtl/mtl_pixel_fifo.sv
// Synchronous pixel FIFO with flush, occupancy count and a registered read port.
// pop loads the head word into rd_data; pop_zero loads zero (underflow pop).
module mtl_pixel_fifo
    import mtl_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = PIXEL_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     pop_zero,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write; a flush discards the word arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Registered read port; holds its value when neither pop nor pop_zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (pop) begin
            rd_data <= mem[rd_ptr];
        end else if (pop_zero) begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/mtl_frame_feeder.sv
// Streams one frame from the SDRAM frame buffer (Avalon-MM pipelined reads) into a
// pixel FIFO and serves the MTL controller's pop interface.
// Optional: MTL_FEEDER_UNDERFLOW_CNT_EN adds the saturating underflow_cnt output.
module mtl_frame_feeder
    import mtl_feeder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FRAME_WORDS = MTL_FRAME_WORDS,
    parameter int unsigned FIFO_DEPTH  = 256,
    parameter int unsigned PREFILL_LVL = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        newframe,
    input  logic        endframe,
    input  logic        read_sdram_en,
    output logic [31:0] read_data,
    output logic        loading,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
`ifdef MTL_FEEDER_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int unsigned IW = $clog2(FRAME_WORDS + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 2;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               loading_d;
    logic [IW-1:0]      issued_q;
    logic [CW-1:0]      outstanding_q;
    logic [CW-1:0]      discard_q;
    logic               stale_q;
    logic [CW-1:0]      fifo_count;

    logic          kill_c;
    logic          acc_c;
    logic          acc_new_c;
    logic          hold_c;
    logic          drop_c;
    logic          push_c;
    logic          pop_c;
    logic          pop_zero_c;
    logic          frame_done_c;
    logic          want_c;
    logic [IW-1:0] issued_n_c;
    logic [SW-1:0] inflight_n_c;

    // Request/response bookkeeping. A request still stalled by waitrequest when the
    // frame is killed is kept on the bus (stale_q) and its response is discarded.
    assign kill_c       = newframe | endframe;
    assign acc_c        = avm_read & ~avm_waitrequest;
    assign acc_new_c    = acc_c & ~stale_q;
    assign hold_c       = avm_read & avm_waitrequest;
    assign drop_c       = avm_readdatavalid & (kill_c | (discard_q != '0));
    assign push_c       = avm_readdatavalid & ~drop_c;
    assign pop_c        = read_sdram_en & (state_q == ST_STREAM) & (fifo_count != '0);
    assign pop_zero_c   = read_sdram_en & ~pop_c;
    assign frame_done_c = (issued_q == IW'(FRAME_WORDS)) && (outstanding_q == '0);
    assign issued_n_c   = issued_q + IW'(acc_new_c);
    // Discards are included so every in-flight response has a FIFO slot reserved.
    assign inflight_n_c = SW'(fifo_count) + SW'(outstanding_q) + SW'(discard_q) + SW'(acc_c);
    assign want_c       = (state_q != ST_IDLE) && (issued_n_c < IW'(FRAME_WORDS))
                          && (inflight_n_c < SW'(FIFO_DEPTH));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and loading flag; newframe overrides endframe.
    always_comb begin
        state_d   = state_q;
        loading_d = loading;
        case (state_q)
            ST_IDLE, ST_STREAM: state_d = state_q;
            ST_PREFILL: begin
                if ((fifo_count >= CW'(PREFILL_LVL)) || frame_done_c) begin
                    state_d   = ST_STREAM;
                    loading_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (endframe) begin
            state_d = ST_IDLE;
        end
        if (newframe) begin
            state_d   = ST_PREFILL;
            loading_d = 1'b1;
        end
    end

    // Loading output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loading <= 1'b1;
        end else begin
            loading <= loading_d;
        end
    end

    // Read master: issue, address advance, outstanding/discard accounting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            avm_read      <= 1'b0;
            avm_address   <= BASE_ADDR;
            issued_q      <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            stale_q       <= 1'b0;
        end else if (kill_c) begin
            outstanding_q <= '0;
            discard_q     <= discard_q + outstanding_q + CW'(acc_c) - CW'(avm_readdatavalid);
            if (newframe) begin
                issued_q <= '0;
            end
            if (hold_c) begin
                stale_q <= 1'b1;
            end else begin
                stale_q  <= 1'b0;
                avm_read <= 1'b0;
                if (newframe) begin
                    avm_address <= BASE_ADDR;
                end
            end
        end else begin
            discard_q     <= discard_q + CW'(acc_c & stale_q) - CW'(drop_c);
            outstanding_q <= outstanding_q + CW'(acc_new_c) - CW'(push_c);
            issued_q      <= issued_n_c;
            if (acc_c && stale_q) begin
                stale_q     <= 1'b0;
                avm_read    <= 1'b0;
                avm_address <= BASE_ADDR;
            end else if (!hold_c) begin
                if (acc_new_c) begin
                    avm_address <= avm_address + 32'(BYTES_PER_WORD);
                end
                avm_read <= want_c;
            end
        end
    end

    mtl_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (kill_c),
        .push      (push_c),
        .push_data (avm_readdata),
        .pop       (pop_c),
        .pop_zero  (pop_zero_c),
        .rd_data   (read_data),
        .count     (fifo_count)
    );

`ifdef MTL_FEEDER_UNDERFLOW_CNT_EN
    // Saturating count of pops that returned zero; cleared at frame start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            underflow_cnt <= '0;
        end else if (newframe) begin
            underflow_cnt <= '0;
        end else if (pop_zero_c && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`else
    // Underflow pops still return zero through the FIFO read port; nothing is counted.
`endif

endmodule

// File: tb/tb_mtl_frame_feeder.sv
// Bench for mtl_frame_feeder: random Avalon slave returning address-as-data and a
// queue-based model of which words reach the controller and in what order.
module tb_mtl_frame_feeder;

    localparam logic [31:0] BASE  = 32'h100;
    localparam int          FW    = 64;
    localparam int          DEPTH = 16;
    localparam int          PRE   = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        newframe;
    logic        endframe;
    logic        read_sdram_en;
    logic [31:0] read_data;
    logic        loading;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
`ifdef MTL_FEEDER_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    always #5 clk = ~clk;

    mtl_frame_feeder #(
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH),
        .PREFILL_LVL (PRE)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .newframe          (newframe),
        .endframe          (endframe),
        .read_sdram_en     (read_sdram_en),
        .read_data         (read_data),
        .loading           (loading),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
`ifdef MTL_FEEDER_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt     (underflow_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        bit          cur;
    } req_t;

    req_t        slave_q[$];
    logic [31:0] exp_fifo[$];

    int checks = 0;
    int errors = 0;

    // Stimulus knobs.
    bit nf_req = 0, ef_req = 0, pop_force = 0, wr_force = 0, want_first = 0;
    int pop_pct = 0, wait_pct = 0, rsp_pct = 70, acc_limit = 1000;

    // Model state.
    logic [31:0] exp_rd = '0;
    bit          exp_loading = 1;
    int          exp_uf = 0;
    bit          in_prefill = 0, in_stream = 0, stale_pend = 0;
    bit          prev_hold = 0, first_pending = 0;
    logic [31:0] prev_addr = '0;
    int          ready_cnt = 0, issued = 0, pops_ok = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cur_count();
        int n = 0;
        foreach (slave_q[i]) if (slave_q[i].cur) n++;
        return n;
    endfunction

    // One clock cycle: check last cycle's outputs, then act as slave and controller.
    task automatic tick();
        bit  kill, acc, success;
        int  cur_out;
        @(negedge clk);
        check_eq("read_data", read_data, exp_rd);
`ifdef MTL_FEEDER_UNDERFLOW_CNT_EN
        check_eq("underflow_cnt", 32'(underflow_cnt), 32'(exp_uf));
`endif
        if (first_pending) begin
            check_eq("first_pop_after_restart", read_data, BASE);
            first_pending = 0;
        end
        if (prev_hold) begin
            check_eq("hold_read", 32'(avm_read), 32'd1);
            check_eq("hold_addr", avm_address, prev_addr);
        end
        if (in_prefill && ready_cnt >= 2) begin
            exp_loading = 0;
            in_prefill  = 0;
            in_stream   = 1;
        end
        check_eq("loading", 32'(loading), 32'(exp_loading));

        kill     = nf_req || ef_req;
        newframe = nf_req;
        endframe = ef_req;
        cur_out  = cur_count();
        avm_waitrequest = wr_force || (cur_out >= acc_limit) ||
                          (int'($urandom_range(99)) < wait_pct);
        acc = avm_read && !avm_waitrequest;

        if (kill) begin
            foreach (slave_q[i]) slave_q[i].cur = 0;
            exp_fifo.delete();
            in_stream  = 0;
            in_prefill = nf_req;
            ready_cnt  = 0;
            if (nf_req) begin
                exp_loading = 1;
                exp_uf      = 0;
                issued      = 0;
                pops_ok     = 0;
            end
        end

        read_sdram_en = !kill && (pop_force || (int'($urandom_range(99)) < pop_pct));
        success = read_sdram_en && in_stream && (exp_fifo.size() > 0);
        if (success) begin
            exp_rd = exp_fifo.pop_front();
            pops_ok++;
            if (want_first) begin
                first_pending = 1;
                want_first    = 0;
            end
        end else if (read_sdram_en) begin
            exp_rd = '0;
            if (exp_uf < 65535) exp_uf++;
        end

        if (slave_q.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
            req_t r = slave_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.addr;
            if (r.cur) exp_fifo.push_back(r.addr);
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end

        if (acc) begin
            if (kill || stale_pend) begin
                slave_q.push_back('{avm_address, 1'b0});
                stale_pend = 0;
            end else begin
                check_eq("avm_address", avm_address, BASE + 32'(4 * issued));
                check_eq("issued_within_frame", 32'(issued < FW), 32'd1);
                issued++;
                slave_q.push_back('{avm_address, 1'b1});
            end
        end
        if (kill && avm_read && avm_waitrequest) stale_pend = 1;

        prev_hold = avm_read && avm_waitrequest;
        prev_addr = avm_address;
        check_eq("occupancy", 32'((exp_fifo.size() + cur_count()) <= DEPTH), 32'd1);
        if (in_prefill && exp_fifo.size() >= PRE) ready_cnt++;
        nf_req    = 0;
        ef_req    = 0;
        pop_force = 0;
    endtask

    task automatic run_until_pops(input int n, input int budget);
        for (int i = 0; i < budget && pops_ok < n; i++) tick();
        check_eq("pops_done", 32'(pops_ok), 32'(n));
    endtask

    task automatic run_until_issued(input int n, input int budget);
        for (int i = 0; i < budget && issued < n; i++) tick();
        check_eq("issued_reached", 32'(issued >= n), 32'd1);
    endtask

    initial begin
        reset_n           = 1'b0;
        newframe          = 1'b0;
        endframe          = 1'b0;
        read_sdram_en     = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_loading", 32'(loading), 32'd1);
        check_eq("rst_avm_read", 32'(avm_read), 32'd0);
        check_eq("rst_read_data", read_data, 32'd0);
        check_eq("rst_avm_address", avm_address, BASE);
        reset_n = 1'b1;
        tick();

        // Frame A: no wait states, random pops, full frame in order.
        wait_pct = 0; rsp_pct = 70; pop_pct = 50;
        nf_req = 1; tick();
        run_until_pops(FW, 3000);
        check_eq("reads_issued", 32'(issued), 32'(FW));
        pop_force = 1; tick(); tick();
        check_eq("underflow_read", read_data, 32'd0);
        pop_pct = 0;
        ef_req = 1; tick();
        pop_force = 1; tick(); tick();
        check_eq("idle_read", read_data, 32'd0);

        // Frame B: random wait states plus a 5-cycle stall mid-burst.
        wait_pct = 30; pop_pct = 50;
        nf_req = 1; tick();
        run_until_issued(30, 2000);
        wr_force = 1;
        repeat (5) tick();
        wr_force = 0;
        run_until_pops(FW, 4000);
        ef_req = 1; tick();
        repeat (5) tick();

        // Frame C: no pops, issuing must stop at FIFO capacity.
        wait_pct = 0; pop_pct = 0; rsp_pct = 70;
        nf_req = 1; tick();
        repeat (150) tick();
        check_eq("stall_issued", 32'(issued), 32'(DEPTH));
        check_eq("stall_level", 32'(exp_fifo.size()), 32'(DEPTH));
        check_eq("stall_avm_read", 32'(avm_read), 32'd0);
        ef_req = 1; tick();
        repeat (30) tick();

        // Frame D: restart with 4 reads outstanding and one request stalled.
        rsp_pct = 0; acc_limit = 4;
        nf_req = 1; tick();
        repeat (40) tick();
        check_eq("outstanding_before_restart", 32'(cur_count()), 32'd4);
        nf_req = 1; want_first = 1; tick();
        acc_limit = 1000; rsp_pct = 60; pop_pct = 50; wait_pct = 20;
        run_until_pops(FW, 4000);
        pop_pct = 0;
        ef_req = 1; tick();
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
